// File: rtl/rvfi_pc_serializer.sv
// rvfi_pc_serializer
//   Collects RVFI retirements from NRET parallel channels and puts them back in
//   strict rvfi_order sequence, using a DEPTH-slot buffer indexed by the low
//   order bits. It then emits one record per handshake on a single channel and
//   checks that each record's pc_rdata equals the pc_wdata of the record that
//   was emitted before it.
//
// Ports
//   clock, reset        rising-edge clock; asynchronous active-high reset
//   rvfi_valid[NRET]    per-channel retirement valid
//   rvfi_order          64 bits per channel, channel c at [64*c +: 64]
//   rvfi_pc_rdata/wdata XLEN bits per channel
//   out_valid/out_ready single-channel handshake
//   out_order           order of the presented record (== next_order)
//   out_pc_rdata/wdata  presented PCs
//   out_pc_mismatch     forward PC check failed (qualified by out_valid)
//   err_window          sticky: an input order fell outside the buffer window
//   err_dup             sticky: an input hit an already-occupied slot
module rvfi_pc_serializer #(
  parameter int NRET  = 2,
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [64*NRET-1:0]   rvfi_order,
  input  logic [XLEN*NRET-1:0] rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0] rvfi_pc_wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_order,
  output logic [XLEN-1:0]      out_pc_rdata,
  output logic [XLEN-1:0]      out_pc_wdata,
  output logic                 out_pc_mismatch,
  output logic                 err_window,
  output logic                 err_dup
);

  localparam int IDXW = $clog2(DEPTH);

  logic [DEPTH-1:0] occ_q, occ_d;
  logic [63:0]      ord_q [DEPTH];
  logic [63:0]      ord_d [DEPTH];
  logic [XLEN-1:0]  rd_q  [DEPTH];
  logic [XLEN-1:0]  rd_d  [DEPTH];
  logic [XLEN-1:0]  wd_q  [DEPTH];
  logic [XLEN-1:0]  wd_d  [DEPTH];

  logic [63:0]      next_order_q, next_order_d;
  logic [XLEN-1:0]  last_wdata_q, last_wdata_d;
  logic             last_valid_q, last_valid_d;
  logic             err_window_q, err_window_d;
  logic             err_dup_q,    err_dup_d;

  logic [IDXW-1:0]  head;
  logic             pop;
  logic [63:0]      ch_order;
  logic [63:0]      ch_dist;
  logic [IDXW-1:0]  ch_idx;
  logic [DEPTH-1:0] written;

  assign head            = next_order_q[IDXW-1:0];
  // The stored order must match: a slot left occupied by an overwrite during
  // its own pop holds an old order and must not be presented again.
  assign out_valid       = occ_q[head] && (ord_q[head] == next_order_q);
  assign out_order       = next_order_q;
  assign out_pc_rdata    = rd_q[head];
  assign out_pc_wdata    = wd_q[head];
  assign out_pc_mismatch = out_valid && last_valid_q && (rd_q[head] != last_wdata_q);
  assign err_window      = err_window_q;
  assign err_dup         = err_dup_q;
  assign pop             = out_valid && out_ready;

  always_comb begin
    occ_d        = occ_q;
    ord_d        = ord_q;
    rd_d         = rd_q;
    wd_d         = wd_q;
    next_order_d = next_order_q;
    last_wdata_d = last_wdata_q;
    last_valid_d = last_valid_q;
    err_window_d = err_window_q;
    err_dup_d    = err_dup_q;
    written      = '0;
    ch_order     = '0;
    ch_dist      = '0;
    ch_idx       = '0;

    if (pop) begin
      occ_d[head]  = 1'b0;
      next_order_d = next_order_q + 64'd1;
      last_wdata_d = wd_q[head];
      last_valid_d = 1'b1;
    end

    // Channels are applied in ascending index so the highest channel wins a
    // same-slot collision. Duplicate detection uses the pre-pop occupancy, so
    // a write into the slot being popped counts as a duplicate and keeps it set.
    for (int unsigned c = 0; c < NRET; c++) begin
      ch_order = rvfi_order[64*c +: 64];
      ch_dist  = ch_order - next_order_q;
      ch_idx   = ch_order[IDXW-1:0];
      if (rvfi_valid[c]) begin
        if (ch_dist >= 64'(DEPTH)) begin
          err_window_d = 1'b1;
        end else begin
          if (occ_q[ch_idx] || written[ch_idx]) err_dup_d = 1'b1;
          written[ch_idx] = 1'b1;
          occ_d[ch_idx]   = 1'b1;
          ord_d[ch_idx]   = ch_order;
          rd_d[ch_idx]    = rvfi_pc_rdata[XLEN*c +: XLEN];
          wd_d[ch_idx]    = rvfi_pc_wdata[XLEN*c +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_q        <= '0;
      next_order_q <= '0;
      last_wdata_q <= '0;
      last_valid_q <= 1'b0;
      err_window_q <= 1'b0;
      err_dup_q    <= 1'b0;
    end else begin
      occ_q        <= occ_d;
      next_order_q <= next_order_d;
      last_wdata_q <= last_wdata_d;
      last_valid_q <= last_valid_d;
      err_window_q <= err_window_d;
      err_dup_q    <= err_dup_d;
    end
  end

  // Slot payload is only observable through an occupied bit, so it needs no reset.
  always_ff @(posedge clock) begin
    ord_q <= ord_d;
    rd_q  <= rd_d;
    wd_q  <= wd_d;
  end

endmodule
